msd_to_bin_decoder: RTL and testbench



---
 rtl/msd_to_bin_decoder.sv | 173 +++++++++++++++++
 tb/tb_msd_to_bin_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/msd_to_bin_decoder.sv
// msd_to_bin_decoder
//   Converts a modified-signed-digit word (codes 00=-1, 01=0, 10=+1,
//   11=illegal, read as 0) into two's-complement binary.
//   The decoder handles CHUNK digits per cycle, least-significant chunk first.
//   A borrow is registered between chunks.
//   Optional build macro: MSD_DEC_EARLY_EXIT_EN. When it is defined, the
//   conversion ends as soon as every remaining upper digit is zero.
//
// Ports
//   clk            clock
//   rst            synchronous, active-high reset
//   in_valid       msd_in is valid
//   in_ready       decoder can accept a word (IDLE)
//   msd_in         MSD word, digit i at msd_in[2i+1:2i]
//   out_valid      bin_out is valid (DONE)
//   out_ready      consumer accepts bin_out
//   bin_out        N_DIG+1 bit two's-complement result, MSB = sign
//   illegal_digit  the latched word contained code 2'b11
module msd_to_bin_decoder #(
    parameter int N_DIG = 77,
    parameter int CHUNK = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*N_DIG-1:0] msd_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_DIG:0]     bin_out,
    output logic               illegal_digit
);

    localparam int NCH   = (N_DIG + CHUNK - 1) / CHUNK;
    localparam int NPAD  = NCH * CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int POS_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    // state | meaning
    // IDLE  | waiting for a word, in_ready=1
    // CONV  | converting chunk idx each cycle
    // DONE  | result presented, out_valid=1
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t state, state_nxt;

    // The input word is padded up to a whole number of chunks with zero digits
    // (2'b01). The current chunk always sits in the low bits of msd_sh.
    logic [2*NPAD-1:0] msd_sh;
    logic [N_DIG-1:0]  res;
    logic [N_DIG-1:0]  res_nxt;
    logic              sign;
    logic              borrow;
    logic              illegal;
    logic [IDX_W-1:0]  idx;
    logic [CHUNK-1:0]  diff;
    logic              borrow_out;
    logic              chunk_illegal;
    logic              finish_conv;

    // Compute P - N - borrow for the current chunk with a ripple borrow.
    always_comb begin : chunk_conv
        logic       b;
        logic [1:0] dig;
        logic       p;
        logic       n;
        b             = borrow;
        diff          = '0;
        chunk_illegal = 1'b0;
        for (int j = 0; j < CHUNK; j++) begin
            dig           = msd_sh[2*j +: 2];
            p             = (dig == 2'b10);
            n             = (dig == 2'b00);
            diff[j]       = p ^ n ^ b;
            b             = (~p & (n | b)) | (n & b);
            chunk_illegal = chunk_illegal | (dig == 2'b11);
        end
        borrow_out = b;
    end

`ifdef MSD_DEC_EARLY_EXIT_EN
    logic upper_zero;
    assign upper_zero  = (msd_sh[2*NPAD-1:2*CHUNK] == {(NPAD-CHUNK){2'b01}});
    assign finish_conv = (idx == LAST_IDX) || upper_zero;
`else
    assign finish_conv = (idx == LAST_IDX);
`endif

    always_comb begin : result_merge
        int pos;
        res_nxt = res;
        for (int j = 0; j < CHUNK; j++) begin
            pos = int'(idx) * CHUNK + j;
            // The last chunk may extend past the top digit.
            if (pos < N_DIG) begin
                res_nxt[POS_W'(pos)] = diff[j];
            end
        end
`ifdef MSD_DEC_EARLY_EXIT_EN
        // The upper digits are all zero, so every higher bit is 0 - 0 - borrow.
        if (upper_zero) begin
            for (int k = 0; k < N_DIG; k++) begin
                if (k >= (int'(idx) + 1) * CHUNK) begin
                    res_nxt[k] = borrow_out;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)    state_nxt = CONV;
            CONV:    if (finish_conv) state_nxt = DONE;
            DONE:    if (out_ready)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msd_sh  <= '0;
            res     <= '0;
            sign    <= 1'b0;
            borrow  <= 1'b0;
            illegal <= 1'b0;
            idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        msd_sh  <= {{(NPAD-N_DIG){2'b01}}, msd_in};
                        res     <= '0;
                        sign    <= 1'b0;
                        borrow  <= 1'b0;
                        illegal <= 1'b0;
                        idx     <= '0;
                    end
                end
                CONV: begin
                    msd_sh  <= {{CHUNK{2'b01}}, msd_sh[2*NPAD-1:2*CHUNK]};
                    res     <= res_nxt;
                    borrow  <= borrow_out;
                    illegal <= illegal | chunk_illegal;
                    idx     <= idx + 1'b1;
                    if (finish_conv) begin
                        sign <= borrow_out;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bin_out       = {sign, res};
    assign illegal_digit = illegal;

endmodule

// File: tb/tb_msd_to_bin_decoder.sv
module tb_msd_to_bin_decoder;

    localparam int ND = 77;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2*ND-1:0]   msd_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ND:0]       bin_out;
    logic              illegal_digit;

    msd_to_bin_decoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .msd_in(msd_in), .out_valid(out_valid), .out_ready(out_ready),
        .bin_out(bin_out), .illegal_digit(illegal_digit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ND:0] bin;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   acc_cyc = 0;

    task automatic check(input string tag, input logic [ND:0] obs, input logic [ND:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*ND-1:0] zero_word();
        logic [2*ND-1:0] w;
        for (int i = 0; i < ND; i++) w[2*i +: 2] = 2'b01;
        return w;
    endfunction

    function automatic logic [2*ND-1:0] set_dig(input logic [2*ND-1:0] w, input int i, input logic [1:0] c);
        logic [2*ND-1:0] r;
        r = w;
        r[2*i +: 2] = c;
        return r;
    endfunction

    function automatic exp_t model(input logic [2*ND-1:0] w);
        exp_t e;
        logic [ND:0] acc;
        int top;
        acc   = '0;
        e.ill = 1'b0;
        top   = 0;
        for (int i = 0; i < ND; i++) begin
            case (w[2*i +: 2])
                2'b10: acc = acc + ((ND+1)'(1) << i);
                2'b00: acc = acc - ((ND+1)'(1) << i);
                2'b11: e.ill = 1'b1;
                default: ;
            endcase
            if (w[2*i +: 2] != 2'b01) top = i / 8;
        end
        e.bin = acc;
`ifdef MSD_DEC_EARLY_EXIT_EN
        e.lat = top + 1;
`else
        e.lat = 10;
`endif
        return e;
    endfunction

    task automatic accept(input logic [2*ND-1:0] w, input bit track);
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout observed in_ready=0 expected in_ready=1");
        end
        in_valid = 1'b1;
        msd_in   = w;
        if (track) sb.push_back(model(w));
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int hold);
        exp_t e;
        int   k;
        k = 0;
        while (!out_valid && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL %s_timeout observed out_valid=0 expected out_valid=1", tag);
            return;
        end
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard observed=empty expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, "_lat"}, (ND+1)'(cyc - acc_cyc), (ND+1)'(e.lat));
        check({tag, "_bin"}, bin_out, e.bin);
        check({tag, "_ill"}, (ND+1)'(illegal_digit), (ND+1)'(e.ill));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_bin"}, bin_out, e.bin);
            check({tag, "_hold_rdy"}, (ND+1)'(in_ready), '0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, (ND+1)'(out_valid), '0);
        check({tag, "_idle_rdy"}, (ND+1)'(in_ready), (ND+1)'(1));
        check({tag, "_keep_bin"}, bin_out, e.bin);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*ND-1:0] w;
        logic [2*ND-1:0] z;
        z = zero_word();

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", (ND+1)'(in_ready), (ND+1)'(1));
        check("rst_out_valid", (ND+1)'(out_valid), '0);
        check("rst_bin", bin_out, '0);
        check("rst_ill", (ND+1)'(illegal_digit), '0);
        @(negedge clk);
        rst = 1'b0;

        accept(z, 1'b1);
        collect("all_zero", 0);

        accept(set_dig(z, 0, 2'b00), 1'b1);
        collect("d0_neg", 0);
        accept(set_dig(z, 0, 2'b10), 1'b1);
        collect("d0_pos", 0);

        accept(set_dig(set_dig(z, 8, 2'b10), 7, 2'b00), 1'b1);
        collect("chunk_b1", 0);
        w = set_dig(z, 8, 2'b10);
        for (int i = 0; i < 8; i++) w = set_dig(w, i, 2'b00);
        accept(w, 1'b1);
        collect("chunk_b2", 0);

        accept(set_dig(z, 76, 2'b00), 1'b1);
        collect("top_neg", 0);
        w = set_dig(z, 76, 2'b10);
        for (int i = 0; i < 76; i++) w = set_dig(w, i, 2'b00);
        accept(w, 1'b1);
        collect("top_pos", 5);

        // Back-to-back accept right after release, with an in_valid pulse during CONV.
        w = set_dig(set_dig(z, 40, 2'b10), 76, 2'b10);
        accept(w, 1'b1);
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        msd_in   = set_dig(z, 76, 2'b00);
        @(negedge clk);
        in_valid = 1'b0;
        collect("ign_valid", 2);
        accept(set_dig(set_dig(z, 3, 2'b10), 76, 2'b00), 1'b1);
        collect("b2b", 0);

        // Reset while chunk 4 is being converted.
        w = set_dig(set_dig(z, 5, 2'b00), 76, 2'b10);
        accept(w, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_rdy", (ND+1)'(in_ready), (ND+1)'(1));
        check("mid_rst_ov", (ND+1)'(out_valid), '0);
        check("mid_rst_bin", bin_out, '0);
        check("mid_rst_ill", (ND+1)'(illegal_digit), '0);
        @(negedge clk);
        rst = 1'b0;
        accept(set_dig(set_dig(z, 70, 2'b00), 2, 2'b10), 1'b1);
        collect("post_rst", 0);

        accept(set_dig(z, 3, 2'b11), 1'b1);
        collect("illegal", 0);

        for (int r = 0; r < 4; r++) begin
            w = z;
            for (int i = 0; i < ND; i++) w = set_dig(w, i, 2'($urandom_range(0, 2)));
            accept(w, 1'b1);
            collect("random", 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
